// File: rtl/ram_16x256_quad_read.sv
// Circular sample buffer for a decimating FIR: one write port, one read port that
// returns the addressed word and the next three (mod depth) with one cycle of latency.
module ram_16x256_quad_read #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q0,
    output logic [DATA_WIDTH-1:0] q1,
    output logic [DATA_WIDTH-1:0] q2,
    output logic [DATA_WIDTH-1:0] q3
);

    localparam int ROW_W = ADDR_WIDTH - 2;
    localparam int ROWS  = 2 ** ROW_W;

    logic [1:0]            rd_off_s  [4];
    logic [ADDR_WIDTH-1:0] rd_addr_s [4];
    logic [ROW_W-1:0]      rd_row_d  [4];
    logic [DATA_WIDTH-1:0] bank_rd_s [4];
    logic [1:0]            align_q;

    // Each bank serves whichever of the four window words falls in it; its row wraps with the address.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            rd_off_s[b]  = 2'(b) - rdaddress[1:0];
            rd_addr_s[b] = rdaddress + ADDR_WIDTH'(rd_off_s[b]);
            rd_row_d[b]  = rd_addr_s[b][ADDR_WIDTH-1:2];
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] bank_q;

        // Write port: this bank owns addresses whose low two bits equal its index.
        always_ff @(posedge clk) begin
            if (reset_n && wren && (wraddress[1:0] == 2'(b))) begin
                mem[wraddress[ADDR_WIDTH-1:2]] <= data;
            end
        end

        // Registered read; a same-cycle write lands after this sample, so old data is returned.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                bank_q <= '0;
            end else begin
                bank_q <= mem[rd_row_d[b]];
            end
        end

        assign bank_rd_s[b] = bank_q;
    end

    // Window alignment travels with the read so the output rotation matches the data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            align_q <= 2'd0;
        end else begin
            align_q <= rdaddress[1:0];
        end
    end

    // Rotate banks so q0 always comes from the bank holding the base address.
    always_comb begin
        q0 = bank_rd_s[align_q];
        q1 = bank_rd_s[align_q + 2'd1];
        q2 = bank_rd_s[align_q + 2'd2];
        q3 = bank_rd_s[align_q + 2'd3];
    end

endmodule

// File: tb/tb_ram_16x256_quad_read.sv
// Scoreboard bench for ram_16x256_quad_read: the driver queues expected windows,
// a monitor pops and compares them one cycle after each checked read is issued.
module tb_ram_16x256_quad_read;

    logic        clk;
    logic        reset_n;
    logic [15:0] data;
    logic [7:0]  wraddress;
    logic        wren;
    logic [7:0]  rdaddress;
    logic [15:0] q0, q1, q2, q3;

    typedef struct {
        logic [63:0] e;
        string       nm;
    } exp_t;

    exp_t exp_q [$];
    logic chk_req;
    int   compared;
    int   mismatched;

    ram_16x256_quad_read dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q0        (q0),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected window after the fill pattern mem[i] = 16'h1000 + i.
    function automatic logic [63:0] fill4(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {{8'h10, a}, {8'h10, a1}, {8'h10, a2}, {8'h10, a3}};
    endfunction

    // Drives one cycle of inputs; inputs change 1 time unit after the posedge.
    task automatic step(input logic rst, input logic we, input logic [7:0] wa,
                        input logic [15:0] wd, input logic [7:0] ra,
                        input logic chk, input logic [63:0] e, input string nm);
        exp_t ent;
        reset_n   = rst;
        wren      = we;
        wraddress = wa;
        data      = wd;
        rdaddress = ra;
        chk_req   = chk;
        if (chk) begin
            ent.e  = e;
            ent.nm = nm;
            exp_q.push_back(ent);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a read checked at posedge N is compared at the following negedge.
    initial begin
        logic launched;
        exp_t ent;
        forever begin
            @(posedge clk);
            launched = chk_req;
            @(negedge clk);
            if (launched) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL scoreboard_underflow: got %h %h %h %h with no expected entry",
                             q0, q1, q2, q3);
                end else begin
                    ent = exp_q.pop_front();
                    if ({q0, q1, q2, q3} !== ent.e) begin
                        mismatched++;
                        $display("FAIL %s: got %h_%h_%h_%h expected %h_%h_%h_%h", ent.nm,
                                 q0, q1, q2, q3, ent.e[63:48], ent.e[47:32],
                                 ent.e[31:16], ent.e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        chk_req    = 1'b0;
        reset_n    = 1'b0;
        wren       = 1'b0;
        wraddress  = 8'h00;
        data       = 16'h0000;
        rdaddress  = 8'h00;

        step(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 64'h0, "reset_state");
        step(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 64'h0, "");

        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 8'(i), 16'h1000 + 16'(i), 8'h00, 1'b0, 64'h0, "");
        end

        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h10, 1'b1, 64'h1010_1011_1012_1013, "fill_0x10");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'hFE, 1'b1, 64'h10FE_10FF_1000_1001, "wrap_0xFE");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'hFF, 1'b1, 64'h10FF_1000_1001_1002, "wrap_0xFF");

        // Back-to-back reads: step 4 keeps alignment 0, step 5 walks through all four alignments.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'h00, 16'h0000, 8'(i * 4), 1'b1, fill4(8'(i * 4)), "stream_step4");
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 8'h00, 16'h0000, 8'(i * 5), 1'b1, fill4(8'(i * 5)), "stream_step5");
        end
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'hFD, 1'b1, 64'h10FD_10FE_10FF_1000, "wrap_0xFD");

        step(1'b1, 1'b1, 8'h20, 16'hAAAA, 8'h00, 1'b0, 64'h0, "");
        step(1'b1, 1'b1, 8'h21, 16'h5555, 8'h20, 1'b1, 64'hAAAA_1021_1022_1023, "collide_q1_old");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h20, 1'b1, 64'hAAAA_5555_1022_1023, "collide_q1_new");

        step(1'b1, 1'b1, 8'h40, 16'hBEEF, 8'h40, 1'b1, 64'h1040_1041_1042_1043, "collide_q0_old");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h3F, 1'b1, 64'h103F_BEEF_1041_1042, "collide_q0_new");

        step(1'b1, 1'b0, 8'h05, 16'hFFFF, 8'h80, 1'b0, 64'h0, "");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h04, 1'b1, 64'h1004_1005_1006_1007, "wren0_hold");

        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h2C, 1'b1, 64'h102C_102D_102E_102F, "pre_reset");
        step(1'b0, 1'b1, 8'h30, 16'h1234, 8'h30, 1'b1, 64'h0, "reset_clears_q");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h30, 1'b1, 64'h1030_1031_1032_1033, "reset_no_write");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h2E, 1'b1, 64'h102E_102F_1030_1031, "post_reset_read");

        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 64'h0, "");
        step(1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 64'h0, "");
        @(negedge clk);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
